// File: rtl/fifo_read_arbiter.sv
// Round-robin read-port scheduler for the async FIFO: grants one consumer at a time,
// bounds each grant by burst length and stall time, and tags popped words with the owner ID.
module fifo_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 4,
    parameter int STALL_LIMIT = 8,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  r_en,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    rdy,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              state_r, state_n_s;
    logic [NUM_REQ-1:0]  gnt_r, gnt_n_s;
    logic [ID_W-1:0]     owner_r, owner_n_s;
    logic [ID_W-1:0]     last_owner_r, last_owner_n_s;
    logic [3:0]          burst_cnt_r, burst_cnt_n_s;
    logic [3:0]          stall_cnt_r, stall_cnt_n_s;
    logic                out_valid_r;
    logic [ID_W-1:0]     out_id_r;
    logic                r_en_s;
    logic [ID_W-1:0]     winner_s;
    logic                own_req_s;
    logic                own_rdy_s;
    logic                stall_cyc_s;
    logic                grant_done_s;

    // Round-robin pick: first set request after last_v, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                                input logic [ID_W-1:0]    last_v);
        logic [ID_W-1:0] pick_v;
        logic [ID_W-1:0] idx_v;
        int              idx;
        pick_v = last_v;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(last_v) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            idx_v = ID_W'(idx);
            if (req_v[idx_v]) begin
                pick_v = idx_v;
            end else begin
                pick_v = pick_v;
            end
        end
        return pick_v;
    endfunction

    assign winner_s    = rr_pick(req, last_owner_r);
    assign own_req_s   = req[owner_r];
    assign own_rdy_s   = rdy[owner_r];
    // Empty cycles are neutral: they neither advance nor clear the stall run.
    assign stall_cyc_s = own_req_s & ~own_rdy_s & ~empty;

    // Next-state, counter and pop-strobe logic for the IDLE/GRANT FSM.
    always_comb begin
        state_n_s      = state_r;
        gnt_n_s        = gnt_r;
        owner_n_s      = owner_r;
        last_owner_n_s = last_owner_r;
        burst_cnt_n_s  = burst_cnt_r;
        stall_cnt_n_s  = stall_cnt_r;
        r_en_s         = 1'b0;
        grant_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                gnt_n_s = {NUM_REQ{1'b0}};
                if (req != {NUM_REQ{1'b0}}) begin
                    state_n_s     = ST_GRANT;
                    owner_n_s     = winner_s;
                    gnt_n_s       = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
                    burst_cnt_n_s = 4'd0;
                    stall_cnt_n_s = 4'd0;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                r_en_s = own_req_s & own_rdy_s & ~empty & ~rrst;
                if (r_en_s && (burst_cnt_r != 4'hF)) begin
                    burst_cnt_n_s = burst_cnt_r + 4'd1;
                end else begin
                    burst_cnt_n_s = burst_cnt_r;
                end
                if (empty) begin
                    stall_cnt_n_s = stall_cnt_r;
                end else if (stall_cyc_s && (stall_cnt_r != 4'hF)) begin
                    stall_cnt_n_s = stall_cnt_r + 4'd1;
                end else if (stall_cyc_s) begin
                    stall_cnt_n_s = stall_cnt_r;
                end else begin
                    stall_cnt_n_s = 4'd0;
                end
                grant_done_s = ~own_req_s
                             | (r_en_s & (burst_cnt_r == 4'(MAX_BURST - 1)))
                             | (stall_cyc_s & (stall_cnt_r == 4'(STALL_LIMIT - 1)));
                if (grant_done_s) begin
                    state_n_s      = ST_IDLE;
                    gnt_n_s        = {NUM_REQ{1'b0}};
                    last_owner_n_s = owner_r;
                    burst_cnt_n_s  = 4'd0;
                    stall_cnt_n_s  = 4'd0;
                end else begin
                    state_n_s = ST_GRANT;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                gnt_n_s   = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // State, grant, counter and return-path registers with synchronous reset.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_r      <= ST_IDLE;
            gnt_r        <= {NUM_REQ{1'b0}};
            owner_r      <= {ID_W{1'b0}};
            last_owner_r <= ID_W'(NUM_REQ - 1);
            burst_cnt_r  <= 4'd0;
            stall_cnt_r  <= 4'd0;
            out_valid_r  <= 1'b0;
            out_id_r     <= {ID_W{1'b0}};
        end else begin
            state_r      <= state_n_s;
            gnt_r        <= gnt_n_s;
            owner_r      <= owner_n_s;
            last_owner_r <= last_owner_n_s;
            burst_cnt_r  <= burst_cnt_n_s;
            stall_cnt_r  <= stall_cnt_n_s;
            out_valid_r  <= r_en_s;
            if (r_en_s) begin
                out_id_r <= owner_r;
            end else begin
                out_id_r <= out_id_r;
            end
        end
    end

    assign r_en      = r_en_s;
    assign gnt       = gnt_r;
    assign out_valid = out_valid_r;
    assign out_id    = out_id_r;
    assign out_data  = rdata;
    assign busy      = (state_r == ST_GRANT);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a grant/pop-count reference model.
module tb_fifo_read_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int SL = 8;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          empty;
    logic [DW-1:0] rdata;
    logic          r_en;
    logic [N-1:0]  req;
    logic [N-1:0]  rdy;
    logic [N-1:0]  gnt;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_id;
    logic          busy;

    fifo_read_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .STALL_LIMIT(SL)
    ) dut (
        .rclk(rclk), .rrst(rrst), .empty(empty), .rdata(rdata), .r_en(r_en),
        .req(req), .rdy(rdy), .gnt(gnt), .out_valid(out_valid),
        .out_data(out_data), .out_id(out_id), .busy(busy)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds the grant, pops and consecutive stalls in this grant.
    bit m_known   = 1'b0;
    bit m_granted = 1'b0;
    int m_owner   = 0;
    int m_last    = N - 1;
    int m_pops    = 0;
    int m_stall   = 0;
    bit m_ov      = 1'b0;
    int m_oid     = 0;

    int exp_ren1 [7] = '{0, 1, 1, 1, 1, 0, 1};
    int exp_ov1  [7] = '{0, 0, 1, 1, 1, 1, 0};
    int exp_gnt1 [7] = '{0, 1, 1, 1, 1, 0, 1};
    int got_ren  [12];
    int got_ov   [12];
    int got_gnt  [12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst  = 1'b1;
        req   = '0;
        rdy   = '0;
        empty = 1'b1;
        step();
        rrst  = 1'b0;
    endtask

    // Per-cycle comparison against the model, then advance the model across the next edge.
    always @(negedge rclk) begin : cmp
        int rq, ry, ro, yo, e_ren, pick;
        bit found;
        rq    = int'(req);
        ry    = int'(rdy);
        ro    = (rq >> m_owner) & 1;
        yo    = (ry >> m_owner) & 1;
        e_ren = (!rrst && m_granted && ro == 1 && yo == 1 && !empty) ? 1 : 0;
        if (m_known || rrst) begin
            check("r_en", int'(r_en), e_ren);
        end
        if (m_known) begin
            check("gnt", int'(gnt), m_granted ? (1 << m_owner) : 0);
            check("busy", int'(busy), int'(m_granted));
            check("out_valid", int'(out_valid), int'(m_ov));
            check("out_id", int'(out_id), m_oid);
            check("gnt_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
            if (m_ov) begin
                check("out_data", int'(out_data), int'(rdata));
            end
        end
        if (rrst) begin
            m_known   = 1'b1;
            m_granted = 1'b0;
            m_last    = N - 1;
            m_pops    = 0;
            m_stall   = 0;
            m_ov      = 1'b0;
            m_oid     = 0;
        end else begin
            m_ov = (e_ren == 1);
            if (e_ren == 1) begin
                m_oid = m_owner;
            end
            if (!m_granted) begin
                found = 1'b0;
                pick  = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && (((rq >> ((m_last + k) % N)) & 1) == 1)) begin
                        found = 1'b1;
                        pick  = (m_last + k) % N;
                    end
                end
                if (found) begin
                    m_granted = 1'b1;
                    m_owner   = pick;
                    m_pops    = 0;
                    m_stall   = 0;
                end
            end else begin
                if (e_ren == 1) m_pops++;
                if (!empty) begin
                    if (ro == 1 && yo == 0) m_stall++;
                    else m_stall = 0;
                end
                if (ro == 0 || m_pops == MB || m_stall == SL) begin
                    m_granted = 1'b0;
                    m_last    = m_owner;
                end
            end
        end
    end

    initial begin
        rrst  = 1'b1;
        req   = '0;
        rdy   = '0;
        empty = 1'b1;
        rdata = '0;
        step();

        // Single requester: 4 pops, one bubble, regrant.
        do_reset();
        req = 4'b0001; rdy = 4'b1111; empty = 1'b0;
        for (int c = 0; c < 7; c++) begin
            rdata = DW'($urandom);
            #2;
            got_ren[c] = int'(r_en);
            got_ov[c]  = int'(out_valid);
            got_gnt[c] = int'(gnt);
            step();
        end
        for (int c = 0; c < 7; c++) begin
            check("single_ren", got_ren[c], exp_ren1[c]);
            check("single_ov", got_ov[c], exp_ov1[c]);
            check("single_gnt", got_gnt[c], exp_gnt1[c]);
        end

        // Consumer 2 stalls: revoked after 8 stall cycles, next grant goes to 1.
        do_reset();
        req = 4'b0100; rdy = 4'b1011; empty = 1'b0;
        step();
        req = 4'b0110;
        for (int c = 1; c <= 10; c++) begin
            #2;
            got_ren[c] = int'(r_en);
            got_gnt[c] = int'(gnt);
            step();
        end
        check("stall_gnt_c1", got_gnt[1], 4);
        check("stall_gnt_c8", got_gnt[8], 4);
        check("stall_gnt_c9", got_gnt[9], 0);
        check("stall_gnt_c10", got_gnt[10], 2);
        for (int c = 1; c <= 9; c++) begin
            check("stall_no_ren", got_ren[c], 0);
        end

        // Reset mid-burst: r_en gated immediately, state cleared, index 0 first.
        do_reset();
        req = 4'b0011; rdy = 4'b1111; empty = 1'b0;
        step();
        step();
        #2;
        check("mid_ren_before", int'(r_en), 1);
        step();
        rrst = 1'b1;
        #2;
        check("mid_ren_in_reset", int'(r_en), 0);
        step();
        rrst = 1'b0;
        #2;
        check("mid_gnt_after", int'(gnt), 0);
        check("mid_busy_after", int'(busy), 0);
        check("mid_ov_after", int'(out_valid), 0);
        step();
        #2;
        check("mid_regrant", int'(gnt), 1);
        step();

        // Randomized traffic with held requests, random readiness, empties and resets.
        for (int c = 0; c < 4000; c++) begin
            rrst  = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
                rdy[b] = ($urandom_range(0, 3) != 0);
            end
            empty = ($urandom_range(0, 3) == 0);
            rdata = DW'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
